// File: rtl/gs_pkg.sv
// gs_pkg: shared constants and types for the goldschmidt issue unit.
// Optional build macro used by the unit: GS_RCORR_EN (divide result correction).
package gs_pkg;

    localparam int LEADS       = 2;
    localparam int WIDTH       = 28;
    localparam int SIZE        = LEADS + WIDTH;
    localparam int DIV_CYCLES  = 12;
    localparam int SQRT_CYCLES = 16;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_SQRT = 2'b01
    } gs_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_CAPT = 2'b10,
        ST_DONE = 2'b11
    } gs_state_e;

    // Final count value of the RUN phase; any nonzero op code means sqrt.
    function automatic logic [CNT_W-1:0] last_count(input logic [1:0] op);
        return (op == OP_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(SQRT_CYCLES - 1);
    endfunction

endpackage

// File: rtl/gs_sched.sv
// gs_sched: combinational control schedule for the iteration datapath.
// Maps the RUN-phase count and the operation onto mux selects and register enables.
module gs_sched
    import gs_pkg::*;
(
    input  logic [CNT_W-1:0] count_i,
    input  logic [1:0]       op_i,
    input  logic             running_i,
    output logic [1:0]       sA_o,
    output logic [1:0]       sB_o,
    output logic             square_o,
    output logic             enN_o,
    output logic             enD_o,
    output logic             enK_o,
    output logic             enQD_o
);

    logic       stage;
    logic       mode;
    logic       rem;
    logic [1:0] phase;

    // Decode count into selects/enables; everything idles at zero outside RUN.
    always_comb begin
        sA_o     = 2'b00;
        sB_o     = 2'b00;
        square_o = 1'b0;
        enN_o    = 1'b0;
        enD_o    = 1'b0;
        enK_o    = 1'b0;
        enQD_o   = 1'b0;

        // Divide: even counts update N, odd counts update D and K.
        stage = count_i[0];
        mode  = (count_i >= 4'd2) && (count_i < 4'd11);
        rem   = (count_i == 4'd11);

        // Sqrt works in triplets: update N, square K, then update D and K.
        case (count_i)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: phase = 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       phase = 2'd1;
            default:                              phase = 2'd2;
        endcase

        if (running_i) begin
            if (op_i == OP_DIV) begin
                sA_o   = {rem, mode};
                sB_o   = {mode, stage};
                enN_o  = ~stage;
                enD_o  = stage;
                enK_o  = stage;
                enQD_o = rem;
            end else begin
                sA_o = (count_i <= 4'd1) ? 2'b00 : 2'b01;
                case (phase)
                    2'd0: begin
                        enN_o = 1'b1;
                        sB_o  = (count_i == 4'd0) ? 2'b00 : 2'b10;
                    end
                    2'd1: begin
                        square_o = 1'b1;
                        enK_o    = 1'b1;
                        sB_o     = 2'b00;
                    end
                    default: begin
                        enD_o = 1'b1;
                        enK_o = 1'b1;
                        sB_o  = (count_i == 4'd2) ? 2'b00 : 2'b11;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/gs_issue_unit.sv
// gs_issue_unit: request/response sequencer for a goldschmidt divide/sqrt datapath.
// Accepts one operation, steps the datapath through its schedule, captures the result.
// Build macro GS_RCORR_EN: subtract one ulp from a divide result when dp_r_sign is set.
module gs_issue_unit #(
    parameter int  LEADS = gs_pkg::LEADS,
    parameter int  WIDTH = gs_pkg::WIDTH,
    localparam int SIZE  = LEADS + WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [SIZE-1:0] req_a,
    input  logic [SIZE-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_q,
    output logic [1:0]      rsp_op,
    output logic [1:0]      dp_op,
    output logic [1:0]      dp_sA,
    output logic [1:0]      dp_sB,
    output logic            dp_square,
    output logic            dp_enN,
    output logic            dp_enD,
    output logic            dp_enK,
    output logic            dp_enQD,
    output logic [SIZE-1:0] dp_n0,
    output logic [SIZE-1:0] dp_d0,
    input  logic [SIZE-1:0] dp_result,
    input  logic            dp_r_sign
);

    import gs_pkg::*;

    gs_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [SIZE-1:0]  n0_q, n0_d;
    logic [SIZE-1:0]  d0_q, d0_d;
    logic [SIZE-1:0]  res_q, res_d;
    logic [SIZE-1:0]  res_fixed;
    logic             hs;
    logic             last;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign hs        = req_valid && req_ready;
    assign last      = (cnt_q == last_count(op_q));

    assign dp_op  = op_q;
    assign dp_n0  = n0_q;
    assign dp_d0  = d0_q;
    assign rsp_q  = res_q;
    assign rsp_op = op_q;

`ifdef GS_RCORR_EN
    // A negative final remainder means the divide quotient overshot by one ulp.
    always_comb begin
        res_fixed = dp_result;
        if ((op_q == OP_DIV) && dp_r_sign) begin
            res_fixed = dp_result - SIZE'(1);
        end
    end
`else
    logic r_sign_unused;
    assign r_sign_unused = dp_r_sign;

    // Result is taken as-is from the datapath.
    always_comb begin
        res_fixed = dp_result;
    end
`endif

    // Next-state logic for the IDLE -> RUN -> CAPT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs)        state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_CAPT;
            ST_CAPT:                state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Operand, counter and result next values; operands stay frozen until the next accept.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        n0_d  = n0_q;
        d0_d  = d0_q;
        res_d = res_q;
        if (hs) begin
            op_d  = req_op;
            n0_d  = req_a;
            d0_d  = (req_op == OP_DIV) ? req_b : '0;
            cnt_d = '0;
        end
        if ((state_q == ST_RUN) && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ST_CAPT) begin
            res_d = res_fixed;
        end
    end

    // State and datapath registers; reset wins over any same-cycle handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            n0_q    <= '0;
            d0_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            n0_q    <= n0_d;
            d0_q    <= d0_d;
            res_q   <= res_d;
        end
    end

    gs_sched u_sched (
        .count_i   (cnt_q),
        .op_i      (op_q),
        .running_i (state_q == ST_RUN),
        .sA_o      (dp_sA),
        .sB_o      (dp_sB),
        .square_o  (dp_square),
        .enN_o     (dp_enN),
        .enD_o     (dp_enD),
        .enK_o     (dp_enK),
        .enQD_o    (dp_enQD)
    );

endmodule

// File: tb/tb_gs_issue_unit.sv
// tb_gs_issue_unit: scoreboard bench with a behavioural datapath stand-in.
module tb_gs_issue_unit;

    localparam int SZ = 30;
    localparam int FW = 28;
`ifdef GS_RCORR_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [SZ-1:0] req_a, req_b;
    logic          rsp_valid, rsp_ready;
    logic [SZ-1:0] rsp_q;
    logic [1:0]    rsp_op, dp_op, dp_sA, dp_sB;
    logic          dp_square, dp_enN, dp_enD, dp_enK, dp_enQD;
    logic [SZ-1:0] dp_n0, dp_d0, dp_result;
    logic          dp_r_sign;

    always #5 clk = ~clk;

    gs_issue_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_op(rsp_op),
        .dp_op(dp_op), .dp_sA(dp_sA), .dp_sB(dp_sB), .dp_square(dp_square),
        .dp_enN(dp_enN), .dp_enD(dp_enD), .dp_enK(dp_enK), .dp_enQD(dp_enQD),
        .dp_n0(dp_n0), .dp_d0(dp_d0), .dp_result(dp_result), .dp_r_sign(dp_r_sign)
    );

    typedef struct {
        logic [1:0]    op;
        logic [SZ-1:0] a;
        logic [SZ-1:0] b;
        logic          sgn;
        logic [SZ-1:0] q;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   busy = 0;
    int   k = 0;
    int   lat = 0;
    bit   rdy_force = 1'b1;
    bit   rdy_val = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r = 0;
        longint unsigned t;
        for (int b = 30; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // Ideal math: quotient a/b or root of a in the fixed-point format.
    function automatic logic [SZ-1:0] ideal(input logic [1:0] op, input logic [SZ-1:0] a,
                                            input logic [SZ-1:0] b);
        longint unsigned num;
        num = longint'(a) << FW;
        if (op != 2'b00) return SZ'(isqrt(num));
        if (b == '0) return '1;
        return SZ'(num / longint'(b));
    endfunction

    // Expected control word {sA,sB,square,enN,enD,enK,enQD} at schedule step c.
    function automatic logic [8:0] sched_exp(input logic [1:0] op, input int c);
        logic [1:0] sa, sb;
        logic sq, en, ed, ek, eq;
        sa = 0; sb = 0; sq = 0; en = 0; ed = 0; ek = 0; eq = 0;
        if (op == 2'b00) begin
            sa = (c == 11) ? 2'b10 : ((c >= 2 && c < 11) ? 2'b01 : 2'b00);
            sb = {(c >= 2 && c < 11), (c % 2 == 1)};
            en = (c % 2 == 0);
            ed = (c % 2 == 1);
            ek = (c % 2 == 1);
            eq = (c == 11);
        end else begin
            sa = (c <= 1) ? 2'b00 : 2'b01;
            case (c % 3)
                0: begin en = 1; sb = (c >= 3) ? 2'b10 : 2'b00; end
                1: begin sq = 1; ek = 1; sb = 2'b00; end
                default: begin ed = 1; ek = 1; sb = (c >= 5) ? 2'b11 : 2'b00; end
            endcase
        end
        return {sa, sb, sq, en, ed, ek, eq};
    endfunction

    // rsp_ready: forced level for directed phases, random otherwise.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor plus datapath stand-in: tracks each accepted op, supplies the result in CAPT.
    initial begin
        bit pend_rst, pend_hs, pend_rsp, idle_chk;
        logic [8:0] ctrl;
        pend_rst = 1; pend_hs = 0; pend_rsp = 0;
        dp_result = '0;
        dp_r_sign = 1'b0;
        forever begin
            @(negedge clk);
            idle_chk = 0;
            if (pend_rst) begin
                busy = 0;
                idle_chk = 1;
            end else if (pend_rsp) begin
                busy = 0;
            end else if (pend_hs) begin
                if (exp_q.size() == 0) begin
                    chk("accept_without_request", 1, 0);
                end else begin
                    cur  = exp_q.pop_front();
                    busy = 1;
                    k    = 0;
                    lat  = (cur.op == 2'b00) ? 12 : 16;
                end
            end else if (busy) begin
                k++;
            end

            dp_result = SZ'($urandom);
            dp_r_sign = 1'(($urandom));
            if (busy && k == lat) begin
                dp_result = ideal(dp_op, dp_n0, dp_d0) + SZ'(cur.sgn);
                dp_r_sign = cur.sgn;
            end

            ctrl = {dp_sA, dp_sB, dp_square, dp_enN, dp_enD, dp_enK, dp_enQD};
            chk("req_ready", req_ready, !busy);
            if (idle_chk) begin
                chk("rst_rsp_q", rsp_q, 0);
                chk("rst_rsp_op", rsp_op, 0);
                chk("rst_dp_n0", dp_n0, 0);
                chk("rst_dp_d0", dp_d0, 0);
                chk("rst_dp_op", dp_op, 0);
            end
            if (!busy) begin
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_ctrl", ctrl, 0);
            end else begin
                chk("dp_op", dp_op, cur.op);
                chk("dp_n0", dp_n0, cur.a);
                chk("dp_d0", dp_d0, (cur.op == 2'b00) ? cur.b : '0);
                if (k < lat) begin
                    chk($sformatf("sched_op%0d_c%0d", cur.op, k), ctrl, sched_exp(cur.op, k));
                    chk("run_rsp_valid", rsp_valid, 0);
                end else begin
                    chk("post_run_ctrl", ctrl, 0);
                end
                if (k == lat) chk("capt_rsp_valid", rsp_valid, 0);
                if (k > lat) begin
                    chk("done_rsp_valid", rsp_valid, 1);
                    chk("rsp_q", rsp_q, cur.q);
                    chk("rsp_op", rsp_op, cur.op);
                end
                if (k > lat + 300) chk("rsp_stuck", k, lat + 1);
            end

            pend_rst = reset;
            pend_hs  = req_valid && req_ready;
            pend_rsp = rsp_valid && rsp_ready;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                         input logic sgn);
        exp_t e;
        int n;
        logic [SZ-1:0] ex;
        @(posedge clk);
        #1;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            chk("req_accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (!reset) begin
            ex = ideal(op, a, (op == 2'b00) ? b : '0);
            e.op = op; e.a = a; e.b = b; e.sgn = sgn;
            e.q  = (op == 2'b00 && CORR) ? ex : ex + SZ'(sgn);
            exp_q.push_back(e);
        end
        #1;
        req_valid = 1'b0;
        req_a = SZ'($urandom);
        req_b = SZ'($urandom);
        req_op = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 400);
        if (busy || exp_q.size() != 0) chk("drain_timeout", n, 0);
    endtask

    // Stimulus: directed cases first, then randomized traffic with random back-pressure.
    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        issue(2'b00, 30'h0C000000, 30'h10000000, 1'b1);
        wait_idle();
        issue(2'b01, 30'h10000000, 30'h03ABCDEF, 1'b0);
        wait_idle();

        rdy_val = 1'b0;
        issue(2'b00, 30'h08000000, 30'h18000000, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_reach_done", rsp_valid, 1);
        repeat (5) @(posedge clk);
        #1 rdy_val = 1'b1;
        wait_idle();

        issue(2'b00, 30'h0A000000, 30'h14000000, 1'b1);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        issue(2'b00, 30'h05000000, 30'h0F000000, 1'b0);
        wait_idle();

        rdy_force = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [SZ-1:0] b;
            b = SZ'($urandom_range(1, 32'h3FFFFFFF));
            issue(2'($urandom_range(0, 3)), SZ'($urandom), b, 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
